if_id_queue: RTL
================

IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 2, which sets the queue entry count; legal values are powers of two, 2 to 8.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: the fetch side presents a fetched instruction.
REQ-005 SHALL have port in_pc, input, 32 bits: PC of the fetched instruction (the instruction-memory address).
REQ-006 SHALL have port in_inst, input, 32 bits: instruction word read from instruction memory.
REQ-007 SHALL have port in_ready, output, 1 bit: the queue accepts an entry this cycle.
REQ-008 SHALL have port out_valid, output, 1 bit: the head entry is valid for the decode stage.
REQ-009 SHALL have port out_pc, output, 32 bits: PC of the head entry.
REQ-010 SHALL have port out_inst, output, 32 bits: instruction word of the head entry.
REQ-011 SHALL have port out_ready, input, 1 bit: decode consumes the head this cycle.
REQ-012 SHALL have port flush, input, 1 bit: a taken branch or jump has been resolved, so all queued entries are wrong-path.
REQ-013 SHALL have port count, output, $clog2(DEPTH)+1 bits: current occupancy.

Function
REQ-014 SHALL push when in_valid && in_ready && !flush, and pop when out_valid && out_ready && !flush.
REQ-015 SHALL drive in_ready = (count != DEPTH); it SHALL be independent of out_ready, with no full-queue pass-through.
REQ-016 SHALL drive out_valid = (count != 0); out_pc and out_inst SHALL come from the head entry.
REQ-017 SHALL give a default latency of 1 cycle: an entry pushed in cycle N appears at the outputs in cycle N+1.
REQ-018 SHALL, on simultaneous push and pop with 0 < count < DEPTH, leave count unchanged and advance both pointers.
REQ-019 SHALL implement read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH without a bubble.
REQ-020 SHALL, on flush, set count to 0 and both pointers to 0 at the next edge, dropping the same-cycle input and suppressing the same-cycle pop.
REQ-021 SHALL keep out_pc and out_inst stable while out_valid && !out_ready; the outputs are don't-care when out_valid = 0.
REQ-022 SHALL give flush priority over push and pop.
REQ-023 SHALL never let count exceed DEPTH or underflow; the bench asserts this.

Reset
REQ-024 SHALL, on reset low, asynchronously clear count, the pointers and out_valid to 0, and set in_ready to 1.
REQ-025 SHALL clear the entry storage to 0 on reset, so out_pc and out_inst read 32'h0 after reset.
REQ-026 SHALL, when reset asserts mid-operation, discard all entries immediately, with no partial push.

Configuration
REQ-027 SHALL, with IF_ID_QUEUE_BYPASS_EN defined, pass the input combinationally to the outputs when count == 0 && in_valid && out_ready && !flush: out_valid = 1, zero latency, no write.
REQ-028 SHALL, with IF_ID_QUEUE_BYPASS_EN defined and count == 0 && in_valid && !out_ready, still expose the entry combinationally and also write it.
REQ-029 SHALL, without IF_ID_QUEUE_BYPASS_EN, have no combinational path from in_* to out_*, and latency SHALL be as in REQ-017.

Structure
REQ-030 SHALL take the fetch_entry_t struct {pc[31:0], inst[31:0]} from the shared pipeline package rv32i_types.
REQ-031 SHALL take the reset-value constant of the entry storage, NOP_INST = 32'h00000013, from the same package; REQ-025 keeps storage at 0, so the constant is declared there for decode use only.
REQ-032 SHALL be a single module with no sub-module, holding a storage array of fetch_entry_t[DEPTH].

Verification
REQ-033 Fill and drain: reset, then push PC 0x60, 0x64, 0x68 with out_ready = 0 and DEPTH = 2 -> in_ready = 0 after 2 pushes and 0x68 is held off; then out_ready = 1 -> out_pc = 0x60, then 0x64, then 0x68 in order.
REQ-034 Streaming: in_valid and out_ready held at 1, PCs 0x60 + 4k for 10 cycles -> count stays at 1 and out_pc lags in_pc by 1 cycle (0 cycles with the bypass macro).
REQ-035 Wrap-around: 7 push/pop pairs with DEPTH = 4 -> the pointers wrap and out_inst matches the pushed order exactly.
REQ-036 Flush: count = 2 and flush pulsed with in_valid = 1 (PC 0x80) -> next cycle count = 0 and out_valid = 0; PC 0x80 is never output.
REQ-037 Reset: assert reset asynchronously between edges while count = 2 -> count = 0, out_valid = 0 and in_ready = 1 without waiting for an edge.
REQ-038 Stall hold: out_valid = 1 and out_ready = 0 for 5 cycles with in_valid toggling -> out_pc and out_inst do not change.

Source files
------------

// File: rtl/rv32i_types.sv
// rv32i_types: shared pipeline types for the fetch/decode boundary.
package rv32i_types;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/if_id_queue.sv
// if_id_queue: IF/ID instruction queue between fetch and decode, with branch flush.
// Define IF_ID_QUEUE_BYPASS_EN for a zero-latency pass-through when the queue is empty.
module if_id_queue
    import rv32i_types::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [31:0]              in_pc,
    input  logic [31:0]              in_inst,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_inst,
    input  logic                     out_ready,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;
    logic          w_byp;
    fetch_entry_t  w_head;

    assign w_head   = r_mem[r_rd_ptr];
    assign in_ready = r_count != FULL;
    assign count    = r_count;
`ifdef IF_ID_QUEUE_BYPASS_EN
    assign w_byp    = r_count == '0 && in_valid && !flush;
    assign out_pc   = r_count == '0 ? in_pc : w_head.pc;
    assign out_inst = r_count == '0 ? in_inst : w_head.inst;
`else
    assign w_byp    = 1'b0;
    assign out_pc   = w_head.pc;
    assign out_inst = w_head.inst;
`endif
    assign out_valid = r_count != '0 || w_byp;
    // A bypassed entry consumed in the same cycle is never stored
    assign w_push = in_valid && in_ready && !flush && !(w_byp && out_ready);
    assign w_pop  = r_count != '0 && out_ready && !flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= '{pc: in_pc, inst: in_inst};
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

endmodule
